dff_pipe_en: RTL and testbench

Parametrised, enable-gated register pipeline (delay line) with per-stage valid tracking, synchronous flush, occupancy count and full/empty flags. It generalises the single enabled flop to DEPTH stages of DATA_WIDTH bits. It is used in the FC/conv datapaths to align operand and partial-sum streams across multi-cycle MAC latency, and it stalls cleanly under a global enable.

---
 rtl/dff_pkg.sv | 23 ++
 rtl/dff_pipe_stage.sv | 54 +++++
 rtl/dff_pipe_en.sv | 95 +++++++++
 tb/tb_dff_pipe_en.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the enable-gated register pipeline.
// The per-stage word type {valid, data} is width-dependent, so each module declares it locally.
package dff_pkg;

    localparam int unsigned DFF_MAX_DEPTH = 64;

    // Elaboration-time ceil(log2(n)); dff_clog2(1) == 0.
    function automatic int unsigned dff_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit dff_depth_ok(input int unsigned depth);
        return (depth >= 1) && (depth <= DFF_MAX_DEPTH);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word, advancing on en and clearing on flush.
// The word is carried as a packed {valid, data} vector.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    input  logic [DATA_WIDTH:0] src_word,
    output logic [DATA_WIDTH:0] word
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } stage_word_t;

    stage_word_t src;
    stage_word_t word_d;
    stage_word_t word_q;

    assign src = src_word;

    always_comb begin
        word_d = word_q;
        if (flush) begin
            word_d.valid = 1'b0;
            if (CLEAR_DATA) begin
                word_d.data = '0;
            end
        end else if (en) begin
            word_d = src;
            // Bubbles carry zero data so taps never show stale words.
            if (CLEAR_DATA && !src.valid) begin
                word_d.data = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/dff_pipe_en.sv
// Enable-gated DEPTH-stage delay line with per-stage valid, synchronous flush,
// registered occupancy count and full/empty flags. All outputs are register-driven.
module dff_pipe_en
    import dff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = dff_clog2(DEPTH + 1)
) (
    input  logic                        pipe_clk,
    input  logic                        pipe_rst,
    input  logic                        pipe_en,
    input  logic                        pipe_flush,
    input  logic                        pipe_valid_i,
    input  logic [DATA_WIDTH-1:0]       pipe_data_i,
    output logic                        pipe_valid_o,
    output logic [DATA_WIDTH-1:0]       pipe_data_o,
    output logic [DEPTH-1:0]            pipe_tap_valid_o,
    output logic [DEPTH*DATA_WIDTH-1:0] pipe_taps_o,
    output logic [CNT_W-1:0]            pipe_count_o,
    output logic                        pipe_empty_o,
    output logic                        pipe_full_o
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } stage_word_t;

    // words[0] is the input; words[k+1] is the register of stage k.
    stage_word_t words [DEPTH+1];

    assign words[0] = {pipe_valid_i, pipe_data_i};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk      (pipe_clk),
            .rst      (pipe_rst),
            .en       (pipe_en),
            .flush    (pipe_flush),
            .src_word (words[k]),
            .word     (words[k+1])
        );

        assign pipe_tap_valid_o[k]                       = words[k+1].valid;
        assign pipe_taps_o[k*DATA_WIDTH +: DATA_WIDTH]   = words[k+1].data;
    end

    assign pipe_valid_o = words[DEPTH].valid;
    assign pipe_data_o  = words[DEPTH].data;

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    logic             full_d;
    logic             full_q;
    logic             empty_d;
    logic             empty_q;

    // Occupancy tracks words entering stage 0 minus the word leaving the last stage.
    always_comb begin
        count_d = count_q;
        if (pipe_flush) begin
            count_d = '0;
        end else if (pipe_en) begin
            case ({pipe_valid_i, words[DEPTH].valid})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge pipe_clk or posedge pipe_rst) begin
        if (pipe_rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign pipe_count_o = count_q;
    assign pipe_full_o  = full_q;
    assign pipe_empty_o = empty_q;

endmodule

// File: tb/tb_dff_pipe_en.sv
// Directed bench for dff_pipe_en: DEPTH=4 with and without data clearing (table driven),
// plus DEPTH=1 and DEPTH=64 instances tracked against a small delay-line model.
module tb_dff_pipe_en;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       vin;
    logic [7:0] din;

    logic        vo4,  e4,  f4;
    logic [7:0]  do4;
    logic [3:0]  tv4;
    logic [31:0] taps4;
    logic [2:0]  cnt4;

    logic        von,  en_e, fn;
    logic [7:0]  don;
    logic [3:0]  tvn;
    logic [31:0] tapsn;
    logic [2:0]  cntn;

    logic        vo1,  e1,  f1;
    logic [7:0]  do1;
    logic [0:0]  tv1;
    logic [7:0]  taps1;
    logic [0:0]  cnt1;

    logic         vo64, e64, f64;
    logic [7:0]   do64;
    logic [63:0]  tv64;
    logic [511:0] taps64;
    logic [6:0]   cnt64;

    int n_tests;
    int n_fail;

    dff_pipe_en #(.DATA_WIDTH(8), .DEPTH(4), .CLEAR_DATA(1'b1)) u_d4 (
        .pipe_clk(clk), .pipe_rst(rst), .pipe_en(en), .pipe_flush(flush),
        .pipe_valid_i(vin), .pipe_data_i(din), .pipe_valid_o(vo4), .pipe_data_o(do4),
        .pipe_tap_valid_o(tv4), .pipe_taps_o(taps4), .pipe_count_o(cnt4),
        .pipe_empty_o(e4), .pipe_full_o(f4)
    );

    dff_pipe_en #(.DATA_WIDTH(8), .DEPTH(4), .CLEAR_DATA(1'b0)) u_d4n (
        .pipe_clk(clk), .pipe_rst(rst), .pipe_en(en), .pipe_flush(flush),
        .pipe_valid_i(vin), .pipe_data_i(din), .pipe_valid_o(von), .pipe_data_o(don),
        .pipe_tap_valid_o(tvn), .pipe_taps_o(tapsn), .pipe_count_o(cntn),
        .pipe_empty_o(en_e), .pipe_full_o(fn)
    );

    dff_pipe_en #(.DATA_WIDTH(8), .DEPTH(1), .CLEAR_DATA(1'b1)) u_d1 (
        .pipe_clk(clk), .pipe_rst(rst), .pipe_en(en), .pipe_flush(flush),
        .pipe_valid_i(vin), .pipe_data_i(din), .pipe_valid_o(vo1), .pipe_data_o(do1),
        .pipe_tap_valid_o(tv1), .pipe_taps_o(taps1), .pipe_count_o(cnt1),
        .pipe_empty_o(e1), .pipe_full_o(f1)
    );

    dff_pipe_en #(.DATA_WIDTH(8), .DEPTH(64), .CLEAR_DATA(1'b1)) u_d64 (
        .pipe_clk(clk), .pipe_rst(rst), .pipe_en(en), .pipe_flush(flush),
        .pipe_valid_i(vin), .pipe_data_i(din), .pipe_valid_o(vo64), .pipe_data_o(do64),
        .pipe_tap_valid_o(tv64), .pipe_taps_o(taps64), .pipe_count_o(cnt64),
        .pipe_empty_o(e64), .pipe_full_o(f64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for the DEPTH=1 (index 0) and DEPTH=64 (index 1) instances.
    bit         m_v [2][64];
    logic [7:0] m_d [2][64];

    typedef struct packed {
        bit          en;
        bit          fl;
        bit          v;
        logic [7:0]  d;
        logic [3:0]  tv;
        logic [31:0] taps;
        logic [31:0] taps_nc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input bit e, input bit f, input bit v, input logic [7:0] d,
                                input logic [3:0] tv, input logic [31:0] taps,
                                input logic [31:0] taps_nc, input logic [2:0] cnt);
        vec_t r;
        r.en = e; r.fl = f; r.v = v; r.d = d;
        r.tv = tv; r.taps = taps; r.taps_nc = taps_nc; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 64; k++) begin
                m_v[m][k] = 1'b0;
                m_d[m][k] = 8'h00;
            end
        end
    endtask

    task automatic model_edge(input bit e, input bit f, input bit v, input logic [7:0] d);
        for (int m = 0; m < 2; m++) begin
            int dep;
            dep = (m == 0) ? 1 : 64;
            if (f) begin
                for (int k = 0; k < 64; k++) begin
                    m_v[m][k] = 1'b0;
                    m_d[m][k] = 8'h00;
                end
            end else if (e) begin
                for (int k = dep - 1; k > 0; k--) begin
                    m_v[m][k] = m_v[m][k-1];
                    m_d[m][k] = m_d[m][k-1];
                end
                m_v[m][0] = v;
                m_d[m][0] = v ? d : 8'h00;
            end
        end
    endtask

    task automatic check_models(input int idx);
        logic [63:0] ev;
        int c1;
        int c64;
        ev  = '0;
        c64 = 0;
        for (int k = 0; k < 64; k++) begin
            ev[k] = m_v[1][k];
            c64 += int'(m_v[1][k]);
        end
        c1 = int'(m_v[0][0]);
        chk("d1_valid", idx, vo1, m_v[0][0]);
        chk("d1_data", idx, do1, m_d[0][0]);
        chk("d1_tap_valid", idx, tv1, m_v[0][0]);
        chk("d1_taps", idx, taps1, m_d[0][0]);
        chk("d1_count", idx, cnt1, c1);
        chk("d1_full", idx, f1, c1 == 1);
        chk("d1_empty", idx, e1, c1 == 0);
        chk("d64_valid", idx, vo64, m_v[1][63]);
        chk("d64_data", idx, do64, m_d[1][63]);
        chk("d64_tap0", idx, taps64[7:0], m_d[1][0]);
        chk("d64_tap_valid", idx, tv64, ev);
        chk("d64_count", idx, cnt64, c64);
        chk("d64_full", idx, f64, c64 == 64);
        chk("d64_empty", idx, e64, c64 == 0);
        chk("d4_popcount", idx, cnt4, $countones(tv4));
        chk("d4n_popcount", idx, cntn, $countones(tvn));
    endtask

    task automatic step(input bit e, input bit f, input bit v, input logic [7:0] d,
                        input int idx);
        en    = e;
        flush = f;
        vin   = v;
        din   = d;
        model_edge(e, f, v, d);
        @(posedge clk);
        #1;
        check_models(idx);
    endtask

    task automatic check_d4_zero(input string tag);
        chk({tag, "_d4_valid"}, 0, vo4, 1'b0);
        chk({tag, "_d4_data"}, 0, do4, 8'h00);
        chk({tag, "_d4_tap_valid"}, 0, tv4, 4'h0);
        chk({tag, "_d4_taps"}, 0, taps4, 32'h0);
        chk({tag, "_d4_count"}, 0, cnt4, 3'd0);
        chk({tag, "_d4_empty"}, 0, e4, 1'b1);
        chk({tag, "_d4_full"}, 0, f4, 1'b0);
        chk({tag, "_d4n_taps"}, 0, tapsn, 32'h0);
        chk({tag, "_d4n_count"}, 0, cntn, 3'd0);
        chk({tag, "_d1_valid"}, 0, vo1, 1'b0);
        chk({tag, "_d64_count"}, 0, cnt64, 7'd0);
        chk({tag, "_d64_empty"}, 0, e64, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        flush   = 1'b0;
        vin     = 1'b0;
        din     = 8'h00;
        model_clear();

        //             en fl v  data   tv       taps          taps (no clear)  cnt
        vecs[0]  = mk(1, 0, 1, 8'h11, 4'b0001, 32'h00000011, 32'h00000011, 3'd1);
        vecs[1]  = mk(1, 0, 1, 8'h22, 4'b0011, 32'h00001122, 32'h00001122, 3'd2);
        vecs[2]  = mk(1, 0, 1, 8'h33, 4'b0111, 32'h00112233, 32'h00112233, 3'd3);
        vecs[3]  = mk(1, 0, 1, 8'h44, 4'b1111, 32'h11223344, 32'h11223344, 3'd4);
        vecs[4]  = mk(0, 0, 1, 8'h99, 4'b1111, 32'h11223344, 32'h11223344, 3'd4);
        vecs[5]  = mk(0, 0, 1, 8'h99, 4'b1111, 32'h11223344, 32'h11223344, 3'd4);
        vecs[6]  = mk(0, 0, 1, 8'h99, 4'b1111, 32'h11223344, 32'h11223344, 3'd4);
        vecs[7]  = mk(1, 0, 1, 8'h55, 4'b1111, 32'h22334455, 32'h22334455, 3'd4);
        vecs[8]  = mk(1, 0, 1, 8'h66, 4'b1111, 32'h33445566, 32'h33445566, 3'd4);
        vecs[9]  = mk(1, 1, 1, 8'h77, 4'b0000, 32'h00000000, 32'h33445566, 3'd0);
        vecs[10] = mk(1, 0, 1, 8'hAA, 4'b0001, 32'h000000AA, 32'h445566AA, 3'd1);
        vecs[11] = mk(1, 0, 0, 8'hBB, 4'b0010, 32'h0000AA00, 32'h5566AABB, 3'd1);
        vecs[12] = mk(1, 0, 1, 8'hCC, 4'b0101, 32'h00AA00CC, 32'h66AABBCC, 3'd2);
        vecs[13] = mk(1, 0, 0, 8'hDD, 4'b1010, 32'hAA00CC00, 32'hAABBCCDD, 3'd2);
        vecs[14] = mk(1, 0, 0, 8'h00, 4'b0100, 32'h00CC0000, 32'hBBCCDD00, 3'd1);
        vecs[15] = mk(1, 0, 0, 8'h00, 4'b1000, 32'hCC000000, 32'hCCDD0000, 3'd1);
        vecs[16] = mk(1, 0, 0, 8'h00, 4'b0000, 32'h00000000, 32'hDD000000, 3'd0);
        vecs[17] = mk(1, 0, 1, 8'h5A, 4'b0001, 32'h0000005A, 32'h0000005A, 3'd1);
        vecs[18] = mk(0, 1, 1, 8'hFF, 4'b0000, 32'h00000000, 32'h0000005A, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        check_d4_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].en, vecs[i].fl, vecs[i].v, vecs[i].d, i);
            chk("d4_tap_valid", i, tv4, vecs[i].tv);
            chk("d4_taps", i, taps4, vecs[i].taps);
            chk("d4_count", i, cnt4, vecs[i].cnt);
            chk("d4_valid_o", i, vo4, vecs[i].tv[3]);
            chk("d4_data_o", i, do4, vecs[i].taps[31:24]);
            chk("d4_full", i, f4, vecs[i].cnt == 3'd4);
            chk("d4_empty", i, e4, vecs[i].cnt == 3'd0);
            chk("d4n_tap_valid", i, tvn, vecs[i].tv);
            chk("d4n_taps", i, tapsn, vecs[i].taps_nc);
            chk("d4n_count", i, cntn, vecs[i].cnt);
            chk("d4n_data_o", i, don, vecs[i].taps_nc[31:24]);
            chk("d4n_valid_o", i, von, vecs[i].tv[3]);
            chk("d4n_empty", i, en_e, vecs[i].cnt == 3'd0);
            chk("d4n_full", i, fn, vecs[i].cnt == 3'd4);
        end

        // Asynchronous reset between clock edges, with words in flight.
        step(1, 0, 1, 8'hC1, 100);
        step(1, 0, 1, 8'hC2, 101);
        step(1, 0, 1, 8'hC3, 102);
        en  = 1'b0;
        vin = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_d4_zero("arst");
        model_clear();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_d4_zero("arst_rel");
        check_models(103);

        // First word after reset leaves exactly DEPTH enabled edges later.
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) step(1, 0, 1, 8'hE5, 200 + k);
            else        step(1, 0, 0, 8'h00, 200 + k);
            chk("lat_d4_valid", k, vo4, k == 4);
            chk("lat_d4_data", k, do4, (k == 4) ? 8'hE5 : 8'h00);
        end

        // Long stream with periodic stalls fills DEPTH=64, then bubbles and a flush.
        for (int i = 0; i < 80; i++) begin
            step((i % 7) != 3, 0, 1, 8'(i + 1), 300 + i);
        end
        chk("d64_filled", 0, f64, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step((i % 4) != 1, 0, (i % 3) != 0, 8'(8'hA0 + i), 400 + i);
        end
        step(1, 1, 1, 8'hEE, 500);
        chk("final_d64_empty", 0, e64, 1'b1);
        chk("final_d4_empty", 0, e4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
